// File: rtl/puzzle_pkg.sv
// Shared types and constants for the sliding-puzzle move controller:
// board geometry, FSM states, direction encoding and neighbour lookup.
package puzzle_pkg;

    localparam int BOARD_DIM = 8;
    localparam int ADDR_W    = 6;
    localparam int TILE_W    = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VB  = 3'd1,
        READ     = 3'd2,
        CAPTURE  = 3'd3,
        WR_TILE  = 3'd4,
        WR_BLANK = 3'd5,
        DONE     = 3'd6
    } state_e;

    typedef struct packed {
        logic              ok;
        logic [ADDR_W-1:0] addr;
    } nbr_t;

    // Address of the cell the blank moves into; ok=0 when that cell is off the board.
    function automatic nbr_t neighbour(input logic [ADDR_W-1:0] pos, input dir_e dir);
        nbr_t       r;
        logic [2:0] row;
        logic [2:0] col;
        row    = pos[5:3];
        col    = pos[2:0];
        r.ok   = 1'b1;
        r.addr = pos;
        case (dir)
            DIR_UP: begin
                if (row == 3'd0) r.ok = 1'b0;
                else             r.addr = {row - 3'd1, col};
            end
            DIR_DOWN: begin
                if (row == 3'(BOARD_DIM - 1)) r.ok = 1'b0;
                else                          r.addr = {row + 3'd1, col};
            end
            DIR_LEFT: begin
                if (col == 3'd0) r.ok = 1'b0;
                else             r.addr = {row, col - 3'd1};
            end
            default: begin
                if (col == 3'(BOARD_DIM - 1)) r.ok = 1'b0;
                else                          r.addr = {row, col + 3'd1};
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/puzzle_move_ctrl_btn_edge.sv
// Button front end: one register stage, rising-edge detect and
// priority encode (up > down > left > right) into a single press.
module btn_edge
    import puzzle_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] btn_i,
    output logic       press_o,
    output dir_e       dir_o
);

    logic [3:0] cur_q;
    logic [3:0] prev_q;
    logic [3:0] rise;

    // Loading both stages with the live buttons during reset hides a button held through reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q  <= btn_i;
            prev_q <= btn_i;
        end else begin
            cur_q  <= btn_i;
            prev_q <= cur_q;
        end
    end

    assign rise = cur_q & ~prev_q;

    always_comb begin
        press_o = |rise;
        dir_o   = DIR_RIGHT;
        if (rise[3])      dir_o = DIR_UP;
        else if (rise[2]) dir_o = DIR_DOWN;
        else if (rise[1]) dir_o = DIR_LEFT;
    end

endmodule

// File: rtl/puzzle_move_ctrl.sv
// Sliding-puzzle move controller: swaps the blank with a neighbour tile during vblank.
// Define MOVE_COUNT_EN to build the saturating move counter; otherwise moveCount is 0.
module puzzle_move_ctrl
    import puzzle_pkg::*;
#(
    parameter logic [5:0] BLANK_INIT = 6'd63,
    parameter logic [4:0] BLANK_CODE = 5'd0,
    parameter int         CNT_W      = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       btn,
    input  logic             vblank,
    output logic             memRE,
    output logic             memWE,
    output logic [5:0]       memRAddr,
    output logic [5:0]       memWAddr,
    output logic [4:0]       memWData,
    input  logic [4:0]       memRData,
    output logic             busy,
    output logic             moveDone,
    output logic             moveReject,
    output logic [CNT_W-1:0] moveCount
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] blank_q, blank_d;
    logic [ADDR_W-1:0] nb_q, nb_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic              rej_q, rej_d;
    logic              press;
    dir_e              dir;
    nbr_t              nbr;

    btn_edge u_btn_edge (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (btn),
        .press_o (press),
        .dir_o   (dir)
    );

    assign nbr = neighbour(blank_q, dir);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            blank_q <= BLANK_INIT;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            rej_q   <= rej_d;
        end
        nb_q   <= nb_d;
        tile_q <= tile_d;
    end

    always_comb begin
        state_d  = state_q;
        blank_d  = blank_q;
        nb_d     = nb_q;
        tile_d   = tile_q;
        rej_d    = 1'b0;
        memRE    = 1'b0;
        memWE    = 1'b0;
        memRAddr = '0;
        memWAddr = '0;
        memWData = '0;
        moveDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    if (nbr.ok) begin
                        nb_d    = nbr.addr;
                        state_d = WAIT_VB;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            WAIT_VB: begin
                if (vblank) state_d = READ;
            end
            READ: begin
                memRE    = 1'b1;
                memRAddr = nb_q;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                tile_d  = memRData;
                state_d = WR_TILE;
            end
            WR_TILE: begin
                memWE    = 1'b1;
                memWAddr = blank_q;
                memWData = tile_q;
                state_d  = WR_BLANK;
            end
            WR_BLANK: begin
                memWE    = 1'b1;
                memWAddr = nb_q;
                memWData = BLANK_CODE;
                blank_d  = nb_q;
                state_d  = DONE;
            end
            DONE: begin
                moveDone = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign moveReject = rej_q;

`ifdef MOVE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == DONE && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign moveCount = cnt_q;
`else
    assign moveCount = '0;
`endif

endmodule

// File: doc/puzzle_move_ctrl.md
PUZZLE_MOVE_CTRL -- requirements
Module: puzzle_move_ctrl

Interface
REQ-001 Parameter BLANK_INIT, default 6'd63, is the board address of the blank tile after reset.
REQ-002 Parameter BLANK_CODE, default 5'd0, is the tile value written into the vacated position.
REQ-003 Parameter CNT_W, default 10, is the move counter width.
REQ-004 Port clock, input, 1: single clock; all logic on posedge clock.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port btn, input, 4: level buttons {up,down,left,right}, bit 3 = up.
REQ-007 Port vblank, input, 1: high while the display is in vertical blanking.
REQ-008 Port memRE / memWE, output, 1 each: board memory read and write enables.
REQ-009 Port memRAddr / memWAddr, output, 6 each: board addresses, addr = {row[2:0], col[2:0]}.
REQ-010 Port memWData, output, 5: write data to board memory.
REQ-011 Port memRData, input, 5: board memory registered read data, valid 1 cycle after memRE.
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port moveDone / moveReject, output, 1 each: single-cycle status pulses.
REQ-014 Port moveCount, output, CNT_W: number of completed moves.

Function
REQ-015 btn SHALL be registered once; a press is a rising edge of the registered value (cur & ~prev).
REQ-016 Simultaneous edges SHALL be resolved by priority up > down > left > right; the lower-priority edges are discarded.
REQ-017 Edges arriving while busy=1 SHALL be discarded, not queued.
REQ-018 Direction names the blank's motion; the neighbour is blank row-1, row+1, col-1 or col+1 respectively.
REQ-019 An out-of-board neighbour (no wrap at row 0/7 or col 0/7) SHALL produce a moveReject pulse in the next cycle, with no memory access, no counter change and the state remaining IDLE.
REQ-020 FSM states SHALL be IDLE, WAIT_VB, READ, CAPTURE, WR_TILE, WR_BLANK, DONE.
REQ-021 IDLE -> WAIT_VB on a valid press; neighbour address is latched.
REQ-022 WAIT_VB -> READ when vblank=1; if vblank is already high the transition occurs on the next clock.
REQ-023 In READ, memRE=1 and memRAddr=neighbour for exactly one cycle; -> CAPTURE.
REQ-024 In CAPTURE, memRData SHALL be latched as the moved tile; -> WR_TILE.
REQ-025 In WR_TILE, memWE=1, memWAddr=blank, memWData=latched tile; -> WR_BLANK.
REQ-026 In WR_BLANK, memWE=1, memWAddr=neighbour, memWData=BLANK_CODE; blank position := neighbour; -> DONE.
REQ-027 In DONE, moveDone=1 and moveCount increments, saturating at all-ones; -> IDLE.
REQ-028 Press-to-moveDone latency SHALL be 6 cycles when vblank is held high.
REQ-029 If vblank falls during READ..DONE, the sequence SHALL still complete.
REQ-030 memRE and memWE SHALL never both be 1 in the same cycle; they are 0 in all other states.

Reset
REQ-031 On reset: state=IDLE, blank=BLANK_INIT, moveCount=0, all outputs 0, registered btn history = current-zero (a button held through reset does not register a press).
REQ-032 Reset mid-sequence SHALL deassert memWE/memRE the next cycle; partial board writes are not undone.

Configuration
REQ-033 With MOVE_COUNT_EN defined, moveCount SHALL behave per REQ-027; without it, moveCount SHALL be tied to 0 and no counter register is built.

Structure
REQ-034 Package puzzle_pkg SHALL hold the FSM state enum, BOARD_DIM=8, ADDR_W=6, TILE_W=5 and the direction encoding.
REQ-035 Sub-module btn_edge (register plus rising edge with priority encode) SHALL be used for REQ-015/016.

Verification
REQ-036 Reset, blank=63, vblank=1; press up -> read addr 55, write 63 <= ram[55], then write 55 <= 0; moveDone at cycle +6; moveCount=1.
REQ-037 blank=63; press right -> moveReject 1 cycle later, no memWE, moveCount unchanged.
REQ-038 vblank=0; press left -> busy=1, no memory access until vblank rises, then read addr 62.
REQ-039 Press up+left in the same cycle -> only up executes (read 55); press down during busy -> ignored.
REQ-040 Assert reset during WR_TILE -> memWE=0 next cycle, blank=63, moveCount=0.
REQ-041 With CNT_W=2, 5 valid moves -> moveCount saturates at 3; without MOVE_COUNT_EN, moveCount stays 0.
